// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and requester IDs for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MC = 1'b1
  } reqId_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester not granted last wins a contention.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  logic Req0,
  input  logic Req1,
  output logic Gnt0,
  output logic Gnt1
);

  reqId_e lastGnt;

  always_comb begin
    Gnt0 = Req0 & (~Req1 | (lastGnt == REQ_MC));
    Gnt1 = Req1 & (~Req0 | (lastGnt == REQ_WB));
  end

  // A grant is always a transfer because grants only follow requests.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lastGnt <= REQ_MC;
    end else if (Gnt0) begin
      lastGnt <= REQ_WB;
    end else if (Gnt1) begin
      lastGnt <= REQ_MC;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB and the multicycle unit,
// and keeps the busy scoreboard of destinations reserved for the multicycle unit.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = regfile_write_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_write_arbiter_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = regfile_write_arbiter_pkg::NUM_REGS
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req0,
  input  logic [ADDR_WIDTH-1:0] Req0Reg,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  output logic                  Gnt0,
  input  logic                  Req1,
  input  logic [ADDR_WIDTH-1:0] Req1Reg,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  output logic                  Gnt1,
  input  logic                  Reserve,
  input  logic [ADDR_WIDTH-1:0] ReserveReg,
  input  logic [ADDR_WIDTH-1:0] CheckReg1,
  input  logic [ADDR_WIDTH-1:0] CheckReg2,
  output logic                  Hazard,
  output logic [NUM_REGS-1:0]   Busy,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite
);

  logic [NUM_REGS-1:0] busyNext;
  logic                regWriteNext;

  rr_arbiter2 uArb (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Req0  (Req0),
    .Req1  (Req1),
    .Gnt0  (Gnt0),
    .Gnt1  (Gnt1)
  );

  // Reserve is applied after the clear so a same-cycle set on one register wins.
  always_comb begin
    busyNext = Busy;
    if (Gnt1) begin
      busyNext[Req1Reg] = 1'b0;
    end
    if (Reserve && (ReserveReg != '0)) begin
      busyNext[ReserveReg] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  always_comb begin
    regWriteNext = (Gnt0 && (Req0Reg != '0)) || (Gnt1 && (Req1Reg != '0));
    Hazard       = Busy[CheckReg1] | Busy[CheckReg2];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Busy          <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      Busy     <= busyNext;
      RegWrite <= regWriteNext;
      if (Gnt0) begin
        WriteRegister <= Req0Reg;
        WriteData     <= Req0Data;
      end else if (Gnt1) begin
        WriteRegister <= Req1Reg;
        WriteData     <= Req1Data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued at issue
// and popped by a monitor whenever RegWrite is seen.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          Clk;
  logic          Rst_n;
  logic          Req0;
  logic [AW-1:0] Req0Reg;
  logic [DW-1:0] Req0Data;
  logic          Gnt0;
  logic          Req1;
  logic [AW-1:0] Req1Reg;
  logic [DW-1:0] Req1Data;
  logic          Gnt1;
  logic          Reserve;
  logic [AW-1:0] ReserveReg;
  logic [AW-1:0] CheckReg1;
  logic [AW-1:0] CheckReg2;
  logic          Hazard;
  logic [NR-1:0] Busy;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          RegWrite;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [AW+DW-1:0] expQ[$];
  logic [DW-1:0]    rfModel [NR];

  regfile_write_arbiter dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Req0          (Req0),
    .Req0Reg       (Req0Reg),
    .Req0Data      (Req0Data),
    .Gnt0          (Gnt0),
    .Req1          (Req1),
    .Req1Reg       (Req1Reg),
    .Req1Data      (Req1Data),
    .Gnt1          (Gnt1),
    .Reserve       (Reserve),
    .ReserveReg    (ReserveReg),
    .CheckReg1     (CheckReg1),
    .CheckReg2     (CheckReg2),
    .Hazard        (Hazard),
    .Busy          (Busy),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file stand-in: commits on the edge after RegWrite is presented.
  always @(posedge Clk) begin
    if (RegWrite) rfModel[WriteRegister] <= WriteData;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushExp(input logic [AW-1:0] r, input logic [DW-1:0] d);
    expQ.push_back({r, d});
  endtask

  always @(negedge Clk) begin
    if (Rst_n && RegWrite) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", {27'd0, WriteRegister, WriteData}, 64'd0);
      end else begin
        logic [AW+DW-1:0] e;
        e = expQ.pop_front();
        check("write_port", {27'd0, WriteRegister, WriteData}, {27'd0, e});
      end
    end
  end

  logic          seqGnt0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [AW-1:0] seqR0   [2] = '{5'd11, 5'd12};
  logic [DW-1:0] seqD0   [2] = '{32'h100, 32'h101};
  logic [AW-1:0] seqR1   [2] = '{5'd13, 5'd14};
  logic [DW-1:0] seqD1   [2] = '{32'h200, 32'h201};

  initial begin
    int i0;
    int i1;
    Rst_n = 1'b0; Req0 = 1'b0; Req0Reg = '0; Req0Data = '0;
    Req1 = 1'b0; Req1Reg = '0; Req1Data = '0;
    Reserve = 1'b0; ReserveReg = '0; CheckReg1 = '0; CheckReg2 = '0;
    repeat (2) cyc();
    Rst_n = 1'b1;
    cyc();

    // Reset in the middle of a pending write; this write must never appear.
    Req0 = 1'b1; Req0Reg = 5'd3; Req0Data = 32'h11; Reserve = 1'b1; ReserveReg = 5'd4;
    cyc();
    Req0 = 1'b0; Reserve = 1'b0;
    check("pre_rst_busy", Busy, 64'h10);
    #1 Rst_n = 1'b0;
    #1;
    check("rst_regwrite", RegWrite, 64'd0);
    check("rst_wreg", WriteRegister, 64'd0);
    check("rst_wdata", WriteData, 64'd0);
    check("rst_busy", Busy, 64'd0);
    #1 Rst_n = 1'b1;
    Req0 = 1'b1; Req0Reg = 5'd5; Req0Data = 32'hA5A5;
    Req1 = 1'b1; Req1Reg = 5'd6; Req1Data = 32'h5A5A;
    #1;
    check("first_contend_gnt0", Gnt0, 64'd1);
    check("first_contend_gnt1", Gnt1, 64'd0);
    pushExp(5'd5, 32'hA5A5);
    cyc();
    Req0 = 1'b0;
    #1;
    check("req1_after_gnt1", Gnt1, 64'd1);
    pushExp(5'd6, 32'h5A5A);
    cyc();
    Req1 = 1'b0;

    // Single WB write and register-file commit one cycle later.
    Req0 = 1'b1; Req0Reg = 5'd8; Req0Data = 32'd25;
    #1;
    check("single_gnt0", Gnt0, 64'd1);
    pushExp(5'd8, 32'd25);
    cyc();
    Req0 = 1'b0;
    check("single_regwrite", RegWrite, 64'd1);
    cyc();
    check("rf_reg8", rfModel[8], 64'd25);
    check("idle_regwrite", RegWrite, 64'd0);

    // Reserve, hazard, and release by the multicycle write.
    Reserve = 1'b1; ReserveReg = 5'd9;
    cyc();
    Reserve = 1'b0; CheckReg1 = 5'd9;
    #1;
    check("busy9_set", Busy, 64'h200);
    check("hazard9", Hazard, 64'd1);
    Req1 = 1'b1; Req1Reg = 5'd9; Req1Data = 32'hDEAD;
    #1;
    check("mc_gnt1", Gnt1, 64'd1);
    pushExp(5'd9, 32'hDEAD);
    cyc();
    Req1 = 1'b0;
    check("busy9_clear", Busy, 64'd0);
    check("hazard9_clear", Hazard, 64'd0);

    // Back-to-back contention: grants alternate starting with WB.
    i0 = 0; i1 = 0;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Req0Reg = seqR0[i0 < 2 ? i0 : 1]; Req0Data = seqD0[i0 < 2 ? i0 : 1];
      Req1Reg = seqR1[i1 < 2 ? i1 : 1]; Req1Data = seqD1[i1 < 2 ? i1 : 1];
      #1;
      check("rr_gnt0", Gnt0, {63'd0, seqGnt0[k]});
      check("rr_gnt1", Gnt1, {63'd0, ~seqGnt0[k]});
      if (seqGnt0[k]) begin
        pushExp(Req0Reg, Req0Data); i0++;
      end else begin
        pushExp(Req1Reg, Req1Data); i1++;
      end
      cyc();
      check("b2b_regwrite", RegWrite, 64'd1);
    end
    Req0 = 1'b0; Req1 = 1'b0;

    // Register 0: accepted but not written; arbitration state still advances.
    Req1 = 1'b1; Req1Reg = 5'd0; Req1Data = 32'h55;
    #1;
    check("reg0_gnt1", Gnt1, 64'd1);
    cyc();
    Req1 = 1'b0;
    check("reg0_regwrite", RegWrite, 64'd0);
    Req0 = 1'b1; Req0Reg = 5'd1; Req1 = 1'b1; Req1Reg = 5'd2;
    #1;
    check("reg0_lastgnt", Gnt0, 64'd1);
    Req0 = 1'b0; Req1 = 1'b0;
    Reserve = 1'b1; ReserveReg = 5'd0;
    cyc();
    Reserve = 1'b0;
    check("reserve0_busy", Busy, 64'd0);

    // Set and clear of the same register in one cycle: set wins.
    Reserve = 1'b1; ReserveReg = 5'd10;
    Req1 = 1'b1; Req1Reg = 5'd10; Req1Data = 32'h77;
    #1;
    check("same_cycle_gnt1", Gnt1, 64'd1);
    pushExp(5'd10, 32'h77);
    cyc();
    Reserve = 1'b0; Req1 = 1'b0;
    CheckReg1 = 5'd0; CheckReg2 = 5'd10;
    #1;
    check("busy10_set_wins", Busy, 64'h400);
    check("hazard_check2", Hazard, 64'd1);
    Req0 = 1'b1; Req0Reg = 5'd10; Req0Data = 32'h88;
    #1;
    check("wb_gnt0", Gnt0, 64'd1);
    pushExp(5'd10, 32'h88);
    cyc();
    Req0 = 1'b0;
    check("wb_keeps_busy", Busy, 64'h400);

    repeat (3) cyc();
    check("queue_drained", expQ.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
